// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs instruction fields into 32-bit ISA words, FIFOs them to imem with auto address
// Optional illegal-opcode check: INST_ENC_ILLEGAL_CHK_EN
module inst_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       words_out,
    output logic              err
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]       r_mem [DEPTH];
    logic [PW:0]       r_wr_ptr;
    logic [PW:0]       r_rd_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_words;
    logic [31:0]       w_word;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
`ifdef INST_ENC_ILLEGAL_CHK_EN
    logic              w_illegal;
    logic              r_err;
`endif

    // Field layout matches the decode stage; unused fields contribute zero bits.
    always_comb begin
        w_word = '0;
`ifdef INST_ENC_ILLEGAL_CHK_EN
        w_illegal = 1'b0;
`endif
        case (in_opcode)
            5'd0:
                w_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            5'd1, 5'd3, 5'd21, 5'd22:
                w_word = {in_opcode, in_target};
            5'd4:
                w_word = {in_opcode, in_rd, 22'b0};
            5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd24, 5'd25, 5'd26, 5'd27:
                w_word = {in_opcode, in_rd, in_rs, in_imm};
            default: begin
`ifdef INST_ENC_ILLEGAL_CHK_EN
                w_word    = '0;
                w_illegal = 1'b1;
`else
                w_word    = {in_opcode, in_rd, in_rs, in_imm};
`endif
            end
        endcase
    end

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign in_ready  = !w_full && !flush;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = w_empty ? 32'h0 : r_mem[r_rd_ptr[PW-1:0]];
    assign out_addr  = r_addr;
    assign words_out = r_words;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_addr   <= ADDR_W'(BASE_ADDR);
            r_words  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[PW-1:0]] <= w_word;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + 1'b1;
                if (r_words != 16'hFFFF)
                    r_words <= r_words + 16'd1;
            end
        end
    end

`ifdef INST_ENC_ILLEGAL_CHK_EN
    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clock) begin
        if (reset)
            r_err <= 1'b0;
        else if (!flush && w_push && w_illegal)
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder
module tb_inst_encoder;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready, err;
    logic [4:0]    in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
    logic [16:0]   in_imm;
    logic [26:0]   in_target;
    logic [31:0]   out_data;
    logic [AW-1:0] out_addr;
    logic [15:0]   words_out;

    inst_encoder #(.DEPTH(4), .ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .words_out(words_out), .err(err)
    );

    always #5 clock = ~clock;

`ifdef INST_ENC_ILLEGAL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [AW-1:0] exp_addr;
    int            exp_words;
    logic          exp_err;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got 0x%08h expected none", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", out_data, mon_e.data);
                chk("out_addr", {30'b0, out_addr}, {30'b0, mon_e.addr});
                if (exp_words < 65535) exp_words++;
            end
        end
    end

    task automatic set_fields(input logic [4:0] op, rd, rs, rt, sh, alu,
                              input logic [16:0] imm, input logic [26:0] tgt);
        in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
    endtask

    task automatic send(input logic [4:0] op, rd, rs, rt, sh, alu,
                        input logic [16:0] imm, input logic [26:0] tgt, input logic [31:0] exp);
        int k;
        set_fields(op, rd, rs, rt, sh, alu, imm, tgt);
        in_valid = 1'b1;
        k = 0;
        @(negedge clock);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clock);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end else begin
            sb.push_back('{data: exp, addr: exp_addr});
            exp_addr = exp_addr + 1'b1;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            k++;
            @(negedge clock);
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d left expected 0", sb.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        sb.delete();
        exp_addr  = '0;
        exp_words = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        exp_err = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", {30'b0, out_addr}, 0);
        chk("rst_words_out", {16'b0, words_out}, 0);
        chk("rst_err", {31'b0, err}, 0);
        @(posedge clock); #1;

        // first word: valid in the cycle right after accept
        out_ready = 1'b1;
        send(0, 3, 1, 2, 0, 0, 17'h0, 27'h0, 32'h00C22000);
        @(negedge clock);
        chk("latency_valid", {31'b0, out_valid}, 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("words_out_1", {16'b0, words_out}, 1);
        @(posedge clock); #1;

        send(5, 5, 0, 0, 0, 0, 17'h1FFFF, 27'h0, 32'h2941FFFF);
        send(0, 4, 4, 4, 0, 6, 17'h0, 27'h0, 32'h01084018);
        send(1, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 17'h1ABCD, 27'd100, 32'h08000064);
        send(4, 31, 7, 9, 5'h15, 5'h0A, 17'h15555, 27'h5A5A5A5, 32'h27C00000);
        send(0, 1, 2, 3, 31, 31, 17'h1FFFF, 27'h7FFFFFF, 32'h00443FFC);
        send(21, 0, 0, 0, 0, 0, 17'h0, 27'h7FFFFFF, 32'hAFFFFFFF);
        send(27, 31, 31, 5'h1F, 5'h1F, 5'h1F, 17'h0, 27'h0, 32'hDFFE0000);
        drain();
        @(negedge clock);
        chk("words_out_8", {16'b0, words_out}, exp_words);
        @(posedge clock); #1;

        // fill with out_ready low: 5th bundle must stall
        out_ready = 1'b0;
        send(2, 1, 1, 0, 0, 0, 17'h00001, 27'h0, 32'h10420001);
        send(6, 2, 2, 0, 0, 0, 17'h00002, 27'h0, 32'h30840002);
        send(7, 3, 3, 0, 0, 0, 17'h00003, 27'h0, 32'h38C60003);
        send(8, 4, 4, 0, 0, 0, 17'h00004, 27'h0, 32'h41080004);
        set_fields(24, 5, 5, 0, 0, 0, 17'h00005, 27'h0);
        in_valid = 1'b1;
        @(negedge clock);
        chk("full_in_ready", {31'b0, in_ready}, 0);
        repeat (3) @(negedge clock);
        chk("full_in_ready_hold", {31'b0, in_ready}, 0);
        chk("stall_out_data", out_data, 32'h10420001);
        chk("stall_out_addr", {30'b0, out_addr}, 0);
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(24, 5, 5, 0, 0, 0, 17'h00005, 27'h0, 32'hC14A0005);
        drain();

        // opcode outside every format
        send(9, 1, 2, 0, 0, 0, 17'h00003, 27'h0, CHK ? 32'h0 : 32'h48440003);
        drain();
        exp_err = CHK;
        @(negedge clock);
        chk("err_after_op9", {31'b0, err}, {31'b0, exp_err});
        @(posedge clock); #1;

        // flush with words queued and an input presented
        out_ready = 1'b0;
        send(25, 1, 0, 0, 0, 0, 17'h0, 27'h0, 32'hC8400000);
        send(26, 2, 0, 0, 0, 0, 17'h0, 27'h0, 32'hD0800000);
        send(3, 0, 0, 0, 0, 0, 17'h0, 27'h1, 32'h18000001);
        set_fields(2, 7, 7, 0, 0, 0, 17'h0007, 27'h0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", {31'b0, in_ready}, 0);
        @(posedge clock); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        clear_model();
        @(negedge clock);
        chk("flush_out_valid", {31'b0, out_valid}, 0);
        chk("flush_out_addr", {30'b0, out_addr}, 0);
        chk("flush_words_out", {16'b0, words_out}, 0);
        chk("flush_err", {31'b0, err}, {31'b0, exp_err});
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(22, 0, 0, 0, 0, 0, 17'h0, 27'h0000ABC, 32'hB0000ABC);
        drain();

        // reset mid-stream
        out_ready = 1'b0;
        send(5, 1, 1, 0, 0, 0, 17'h1, 27'h0, 32'h28420001);
        send(5, 2, 2, 0, 0, 0, 17'h2, 27'h0, 32'h28840002);
        send(5, 3, 3, 0, 0, 0, 17'h3, 27'h0, 32'h28C60003);
        set_fields(5, 4, 4, 0, 0, 0, 17'h4, 27'h0);
        in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        clear_model();
        exp_err = 1'b0;
        @(negedge clock);
        chk("mrst_out_valid", {31'b0, out_valid}, 0);
        chk("mrst_out_addr", {30'b0, out_addr}, 0);
        chk("mrst_words_out", {16'b0, words_out}, 0);
        chk("mrst_err", {31'b0, err}, {31'b0, exp_err});
        chk("mrst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(0, 3, 1, 2, 0, 0, 17'h0, 27'h0, 32'h00C22000);
        drain();
        @(negedge clock);
        chk("final_words_out", {16'b0, words_out}, exp_words);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
